// File: rtl/distance_pkg.sv
// Shared types for the distance sensing path.
package distance_pkg;

  typedef logic [7:0] distance_t;

  typedef enum logic {
    FILL,
    RUN
  } filt_state_t;

  localparam distance_t DIST_TIMEOUT = 8'hFF;

endpackage

// File: rtl/moving_avg_buffer.sv
// Circular sample buffer with running sum over 2^DEPTH_LOG2 entries.
module moving_avg_buffer #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3,
  localparam int SW        = WIDTH + DEPTH_LOG2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic [SW-1:0]    sum_next,
  output logic             wrap
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      buf_q [DEPTH];
  logic [WIDTH-1:0]      buf_d [DEPTH];
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
  logic [SW-1:0]         sum_q, sum_d;

  always_comb begin
    buf_d = buf_q;
    ptr_d = ptr_q;
    sum_d = sum_q;
    if (wr_en) begin
      // Oldest sample leaves as the new one enters.
      sum_d = sum_q + SW'(din) - SW'(buf_q[ptr_q]);
      buf_d[ptr_q] = din;
      ptr_d = ptr_q + DEPTH_LOG2'(1);
    end
  end

  assign sum_next = sum_d;
  assign wrap     = wr_en && (ptr_q == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      ptr_q <= '0;
      sum_q <= '0;
    end else begin
      buf_q <= buf_d;
      ptr_q <= ptr_d;
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/distance_filter.sv
// Moving-average distance filter with hysteretic near flag.
// Optional DISTANCE_FILTER_DROPOUT_EN rejects all-ones timeout samples.
module distance_filter
  import distance_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3,
  parameter int NEAR_CM    = 20,
  parameter int FAR_CM     = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] distance,
  input  logic             distance_valid,
  output logic [WIDTH-1:0] filtered,
  output logic             filtered_valid,
  output logic             near,
  output logic             full
`ifdef DISTANCE_FILTER_DROPOUT_EN
  ,
  output logic             dropout
`endif
);

  localparam int SW = WIDTH + DEPTH_LOG2;
  localparam logic [WIDTH-1:0] NEAR_V = WIDTH'(NEAR_CM);
  localparam logic [WIDTH-1:0] FAR_V  = WIDTH'(FAR_CM);

  logic             accept;
  logic [SW-1:0]    sum_next;
  logic             wrap;
  logic [WIDTH-1:0] avg;

  filt_state_t      state_q, state_d;
  logic [WIDTH-1:0] filtered_q, filtered_d;
  logic             fv_q, fv_d;
  logic             near_q, near_d;
  logic             full_q, full_d;
  logic             emit;

`ifdef DISTANCE_FILTER_DROPOUT_EN
  logic timeout;
  logic dropout_q, dropout_d;

  assign timeout   = distance == {WIDTH{1'b1}};
  assign accept    = distance_valid && !timeout;
  assign dropout_d = distance_valid && timeout;
  assign dropout   = dropout_q;

  always_ff @(posedge clk) begin
    if (rst) dropout_q <= 1'b0;
    else     dropout_q <= dropout_d;
  end
`else
  assign accept = distance_valid;
`endif

  moving_avg_buffer #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (accept),
    .din      (distance),
    .sum_next (sum_next),
    .wrap     (wrap)
  );

  assign avg = WIDTH'(sum_next >> DEPTH_LOG2);

  always_comb begin
    state_d    = state_q;
    full_d     = full_q;
    filtered_d = filtered_q;
    near_d     = near_q;
    fv_d       = 1'b0;
    emit       = 1'b0;
    if (accept) begin
      unique case (state_q)
        // Pointer starts at zero, so its first wrap marks a full window.
        FILL: if (wrap) begin
          state_d = RUN;
          full_d  = 1'b1;
          emit    = 1'b1;
        end
        RUN: emit = 1'b1;
        default: state_d = FILL;
      endcase
    end
    if (emit) begin
      filtered_d = avg;
      fv_d       = 1'b1;
      if (avg < NEAR_V)     near_d = 1'b1;
      else if (avg > FAR_V) near_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      full_q     <= 1'b0;
      filtered_q <= '0;
      fv_q       <= 1'b0;
      near_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      filtered_q <= filtered_d;
      fv_q       <= fv_d;
      near_q     <= near_d;
    end
  end

  assign filtered       = filtered_q;
  assign filtered_valid = fv_q;
  assign near           = near_q;
  assign full           = full_q;

endmodule

// File: tb/tb_distance_filter.sv
// Scoreboard bench for distance_filter against a window-queue model.
module tb_distance_filter;

  localparam int NEAR = 20;
  localparam int FAR  = 30;
  localparam int N    = 8;
`ifdef DISTANCE_FILTER_DROPOUT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] distance = '0;
  logic       distance_valid = 1'b0;
  logic [7:0] filtered;
  logic       filtered_valid;
  logic       near;
  logic       full;
`ifdef DISTANCE_FILTER_DROPOUT_EN
  logic       dropout;
`endif

  always #5 clk = ~clk;

  distance_filter dut (
    .clk            (clk),
    .rst            (rst),
    .distance       (distance),
    .distance_valid (distance_valid),
    .filtered       (filtered),
    .filtered_valid (filtered_valid),
    .near           (near),
    .full           (full)
`ifdef DISTANCE_FILTER_DROPOUT_EN
    ,
    .dropout        (dropout)
`endif
  );

  typedef struct {
    int f;
    bit n;
  } exp_t;

  exp_t sb[$];
  int   win[$];
  int   acc_cnt = 0;
  int   m_filt = 0;
  bit   m_near = 0, m_full = 0, m_fv = 0, m_drop = 0;
  int   checks = 0, failures = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic accept_sample(int d);
    int s;
    int avg;
    win.push_back(d);
    if (win.size() > N) void'(win.pop_front());
    acc_cnt++;
    if (acc_cnt >= N) begin
      s = 0;
      foreach (win[i]) s += win[i];
      avg = s / N;
      if (avg < NEAR)     m_near = 1;
      else if (avg > FAR) m_near = 0;
      m_filt = avg;
      m_full = 1;
      m_fv   = 1;
      sb.push_back('{avg, m_near});
    end
  endtask

  // Model state after this call describes the DUT after the next posedge.
  task automatic drive(bit r, bit v, int d);
    @(negedge clk);
    rst            = r;
    distance_valid = v;
    distance       = 8'(d);
    m_fv   = 0;
    m_drop = 0;
    if (r) begin
      win.delete();
      acc_cnt = 0;
      m_filt  = 0;
      m_near  = 0;
      m_full  = 0;
    end else if (v) begin
      if (DROP_EN && d == 255) m_drop = 1;
      else accept_sample(d);
    end
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, 0, 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    chk("filtered", int'(filtered), m_filt);
    chk("near", int'(near), int'(m_near));
    chk("full", int'(full), int'(m_full));
    chk("filtered_valid", int'(filtered_valid), int'(m_fv));
`ifdef DISTANCE_FILTER_DROPOUT_EN
    chk("dropout", int'(dropout), int'(m_drop));
`endif
    if (filtered_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: got unexpected filtered_valid, required none at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("sb_filtered", int'(filtered), e.f);
        chk("sb_near", int'(near), int'(e.n));
      end
    end
  end

  initial begin
    int pick;
    int d;
    drive(1, 0, 0);
    drive(1, 0, 0);
    idle(2);
    repeat (8) drive(0, 1, 40);
    idle(1);
    repeat (6) drive(0, 1, 10);
    idle(2);
    repeat (8) drive(0, 1, 25);
    drive(0, 1, 50);
    idle(1);
    drive(0, 1, 50);
    idle(2);
    drive(1, 0, 0);
    repeat (8) drive(0, 1, 40);
    drive(0, 1, 255);
    drive(0, 1, 40);
    idle(2);
    drive(1, 0, 0);
    for (int i = 0; i < 16; i++) drive(0, 1, (i % 2) ? 255 : 0);
    idle(2);
    drive(1, 0, 0);
    repeat (5) drive(0, 1, int'($urandom_range(0, 100)));
    drive(1, 1, 99);
    repeat (8) drive(0, 1, 60);
    idle(2);
    repeat (3000) begin
      pick = int'($urandom_range(0, 15));
      if (pick == 0)      d = 255;
      else if (pick == 1) d = int'($urandom_range(0, 254));
      else                d = int'($urandom_range(10, 40));
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0, d);
    end
    idle(3);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/distance_filter.md
Name: distance_filter

Overview:
- Downstream consumer of sensor_driver's 8-bit distance measurement.
- Keeps a moving average over 2^DEPTH_LOG2 samples and issues a registered filtered distance plus a one-cycle valid strobe.
- Drives a proximity flag with hysteresis. This flag replaces the raw single-sample proximity indication on LEDs and in downstream logic.

Parameters:
WIDTH, 8, bit width of the distance samples in cm
DEPTH_LOG2, 3, log2 of the averaging window (default 8 samples)
NEAR_CM, 20, near flag sets when the average is strictly below this value
FAR_CM, 30, near flag clears when the average is strictly above this value (requires FAR_CM >= NEAR_CM)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
distance  in  WIDTH  raw distance from sensor_driver
distance_valid  in  1  one-cycle pulse; distance is a new measurement this cycle
filtered  out  WIDTH  moving-average distance
filtered_valid  out  1  one-cycle pulse; filtered was updated this cycle
near  out  1  hysteretic proximity flag
full  out  1  window filled; filtered is meaningful

Behaviour:
- Reset is synchronous and active-high on rst, with clk as the only clock.
- Reset values:
  - all outputs are 0;
  - sample buffer entries are 0;
  - running sum is 0;
  - write pointer is 0;
  - fill count is 0;
  - FSM is in FILL.
- State: a circular buffer of 2^DEPTH_LOG2 entries, each WIDTH bits wide.
- Running sum width is WIDTH+DEPTH_LOG2 bits and never overflows.
- Update, on a cycle where distance_valid=1:
  - sum <= sum + distance - buf[wr_ptr];
  - buf[wr_ptr] <= distance;
  - wr_ptr <= wr_ptr+1, wrapping modulo 2^DEPTH_LOG2 with no special case.
- FSM FILL:
  - each accepted sample increments the fill count;
  - filtered_valid stays 0;
  - near does not change;
  - on the 2^DEPTH_LOG2-th sample, the FSM moves to RUN and sets full=1 in the same update.
- FSM RUN:
  - each accepted sample is treated identically;
  - full stays 1 until reset.
- Output latency is 1 cycle. On the clock edge after the last fill sample (or any RUN sample):
  - filtered <= new_sum >> DEPTH_LOG2 (truncating);
  - filtered_valid is 1 for exactly one cycle.
- Hysteresis is evaluated on the new average in that same update:
  - if avg < NEAR_CM, near <= 1;
  - else if avg > FAR_CM, near <= 0;
  - otherwise near holds.
- Between updates, filtered and near hold their values.
- Back-to-back distance_valid on consecutive cycles must be accepted every cycle with no lost samples.
- rst has priority over distance_valid in the same cycle; the sample is dropped.
- Reset mid-fill or mid-run clears everything. After reset, a full fresh window is required before filtered_valid asserts again.
- Inputs outside the valid strobe are ignored.

Optional Feature:
- Macro: DISTANCE_FILTER_DROPOUT_EN.
- When defined:
  - a sample equal to all-ones (2^WIDTH-1, the out-of-range/timeout value) is rejected: no buffer, sum, pointer, count or output change;
  - an extra output `dropout` (1 bit) pulses high one cycle after the rejected strobe; it resets to 0.
- When undefined:
  - all-ones samples are averaged like any other;
  - the `dropout` port does not exist.

Decomposition:
- Package distance_pkg holds:
  - typedef distance_t (logic [7:0]), shared with sensor_driver;
  - state enum filt_state_t {FILL, RUN};
  - constant DIST_TIMEOUT = 8'hFF.
- One sub-module, moving_avg_buffer, holds the circular buffer, pointer and running sum, and outputs the sum and a wrap indication.
- Hysteresis and the FSM stay in distance_filter.

Test Plan:
- Fill: reset, then seven pulses of distance=40 give filtered_valid=0 and full=0. The 8th pulse gives filtered_valid=1 one cycle later, filtered=40, full=1, near=0.
- Near set: after the fill above, send pulses of 10. Averages are 36,32,28,25,21 with near=0, then the 6th pulse gives avg 17 and near=1.
- Hysteresis hold: with near=1, eight pulses of 25 give filtered steady at 25 and near stays 1. Then pulses of 50 give avg 28 (near=1), then 31 (near=0).
- Back-to-back: 16 consecutive-cycle pulses alternating 0/255 give 9 filtered_valid pulses (the 8th through 16th samples), every filtered=127, and no missed update.
- Reset mid-operation: after 5 fill samples, assert rst together with distance_valid. Result is all outputs 0 and the sample dropped; 8 new samples of 60 are then needed before filtered=60.
- DROPOUT_EN: in RUN at avg 40, send 255 → dropout=1 for one cycle, filtered_valid=0, and the next 40 sample yields filtered=40.
